// File: rtl/ifft_butterfly_seq_pkg.sv
// fft_pkg: definitions shared by the FFT / IFFT butterfly stages.
//   DW_DEF      default component width
//   TW_FRAC     fractional bits of a Q1.(DW-1) twiddle at the default width
//   bfly_state_t  butterfly sequencer states
//   cpx_re/cpx_im extract sign-extended components from a packed complex word
//   sat           clamp a value to a signed width and report clipping
package fft_pkg;

    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned TW_FRAC = DW_DEF - 1;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } bfly_state_t;

    // Real part sits in the upper half of a 2*dw packed word.
    function automatic logic signed [31:0] cpx_re(input logic [63:0] x, input int unsigned dw);
        logic [63:0] t;
        t = x << (64 - 2 * dw);
        return 32'($signed(t) >>> (64 - dw));
    endfunction

    // Imaginary part sits in the lower half.
    function automatic logic signed [31:0] cpx_im(input logic [63:0] x, input int unsigned dw);
        logic [63:0] t;
        t = x << (64 - dw);
        return 32'($signed(t) >>> (64 - dw));
    endfunction

    function automatic logic signed [31:0] sat(input  logic signed [31:0] x,
                                               input  int unsigned        dw,
                                               output logic               clipped);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] r;
        hi      = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo      = -(32'sd1 <<< (dw - 1));
        r       = x;
        clipped = 1'b0;
        if (x > hi) begin
            r       = hi;
            clipped = 1'b1;
        end else if (x < lo) begin
            r       = lo;
            clipped = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_butterfly_seq_if.sv
// Operand / result handshake bundle for ifft_butterfly_seq.
//   in_valid/in_ready   operand handshake (in1, in2, tf)
//   out_valid/out_ready result handshake (out1, out2)
//   ovf/ovf_clr         sticky saturation flag and its clear
// master = sequencer side, slave = butterfly side.
interface ifft_butterfly_seq_if #(
    parameter int unsigned DW = fft_pkg::DW_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] in1;
    logic [2*DW-1:0] in2;
    logic [2*DW-1:0] tf;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] out1;
    logic [2*DW-1:0] out2;
    logic            ovf;
    logic            ovf_clr;

    modport master (
        output in_valid, in1, in2, tf, out_ready, ovf_clr,
        input  in_ready, out_valid, out1, out2, ovf
    );

    modport slave (
        input  in_valid, in1, in2, tf, out_ready, ovf_clr,
        output in_ready, out_valid, out1, out2, ovf
    );
endinterface

// File: rtl/ifft_butterfly_seq.sv
// Sequential inverse radix-2 (Gentleman-Sande) butterfly.
//   out1 = (a+b)/2, out2 = (a-b)*conj(w)/2 (saturated), one shared multiplier
//   used over four cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ifft_butterfly_seq_if.slave (operand/result handshakes, ovf)
module ifft_butterfly_seq
    import fft_pkg::*;
#(
    parameter int unsigned DW = DW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ifft_butterfly_seq_if.slave   bus
);

    localparam int unsigned AW = 2 * DW + 2;

    bfly_state_t state, state_nxt;

    logic [1:0]           cnt;
    logic signed [DW:0]   sr, si, dr, di;
    logic signed [DW-1:0] wr, wi;
    logic signed [AW-1:0] acc_r, acc_i;

    logic [2*DW-1:0] out1_q, out2_q;
    logic            out_valid_q, ovf_q;

    logic in_ready, accept, load, consume;

    logic signed [31:0] ar, ai, br, bi, twr, twi;

    logic signed [DW:0]   mul_a;
    logic signed [DW-1:0] mul_b;
    logic signed [AW-1:0] prod, acc_i_fin, sh_r, sh_i;
    logic signed [31:0]   sat_r, sat_i;
    logic                 clip_r, clip_i;
    logic signed [DW:0]   half_r, half_i;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = MUL;
            MUL:  if (cnt == 2'd3) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = bus.in_valid ? MUL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
        accept   = bus.in_valid && in_ready;
        load     = (state == MUL) && (cnt == 2'd3);
        consume  = (state == DONE) && bus.out_ready;
    end

    // ---------------- operand unpacking ----------------
    always_comb begin
        ar  = cpx_re(64'(bus.in1), DW);
        ai  = cpx_im(64'(bus.in1), DW);
        br  = cpx_re(64'(bus.in2), DW);
        bi  = cpx_im(64'(bus.in2), DW);
        twr = cpx_re(64'(bus.tf),  DW);
        twi = cpx_im(64'(bus.tf),  DW);
    end

    // ---------------- shared multiplier ----------------
    // Operand schedule: dr*wr, di*wi, di*wr, dr*wi.
    always_comb begin
        mul_a = cnt[0] ^ cnt[1] ? di : dr;
        mul_b = cnt[0] ? wi : wr;
        prod  = AW'(mul_a) * AW'(mul_b);
    end

    // ---------------- output formatting ----------------
    // The imaginary accumulator completes on the load edge itself, so its
    // final value is taken from the adder rather than the register.
    always_comb begin
        acc_i_fin = acc_i - prod;
        sh_r      = acc_r >>> DW;
        sh_i      = acc_i_fin >>> DW;
        clip_r    = 1'b0;
        clip_i    = 1'b0;
        sat_r     = sat(32'(sh_r), DW, clip_r);
        sat_i     = sat(32'(sh_i), DW, clip_i);
        half_r    = sr >>> 1;
        half_i    = si >>> 1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sr          <= '0;
            si          <= '0;
            dr          <= '0;
            di          <= '0;
            wr          <= '0;
            wi          <= '0;
            acc_r       <= '0;
            acc_i       <= '0;
            out1_q      <= '0;
            out2_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (accept) begin
                sr  <= (DW+1)'(ar + br);
                si  <= (DW+1)'(ai + bi);
                dr  <= (DW+1)'(ar - br);
                di  <= (DW+1)'(ai - bi);
                wr  <= DW'(twr);
                wi  <= DW'(twi);
                cnt <= '0;
            end else if (state == MUL) begin
                cnt <= cnt + 2'd1;
            end

            if (state == MUL) begin
                case (cnt)
                    2'd0: acc_r <= prod;
                    2'd1: acc_r <= acc_r + prod;
                    2'd2: acc_i <= prod;
                    2'd3: acc_i <= acc_i_fin;
                endcase
            end

            if (load) begin
                out1_q      <= {half_r[DW-1:0], half_i[DW-1:0]};
                out2_q      <= {sat_r[DW-1:0], sat_i[DW-1:0]};
                out_valid_q <= 1'b1;
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end

            if (load && (clip_r || clip_i)) ovf_q <= 1'b1;
            else if (bus.ovf_clr)           ovf_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out1      = out1_q;
    assign bus.out2      = out2_q;
    assign bus.ovf       = ovf_q;

endmodule
